// File: rtl/eu_pkg.sv
// eu_pkg: opcode constants, issue-queue FSM encoding and the opcode legality helper.
package eu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;

  localparam logic [15:0] ILLEGAL_RESULT = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } eu_state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MUL, OP_DIV: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/eu_issue_queue_if.sv
// eu_issue_queue_if: instruction, EU and result handshakes of the issue queue.
// slave = the queue itself, master = its environment (producer, EU, consumer).
interface eu_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               in_opcode;
  logic [7:0]               in_a;
  logic [7:0]               in_b;
  logic [TAG_W-1:0]         in_tag;
  logic                     eu_start;
  logic [3:0]               eu_opcode;
  logic [7:0]               eu_a;
  logic [7:0]               eu_b;
  logic                     eu_busy;
  logic                     eu_done;
  logic [15:0]              eu_result;
  logic                     res_valid;
  logic                     res_ready;
  logic [15:0]              res_data;
  logic [TAG_W-1:0]         res_tag;
  logic                     res_err;
  logic [$clog2(DEPTH):0]   q_count;

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, in_tag,
    input  eu_busy, eu_done, eu_result, res_ready,
    output in_ready, eu_start, eu_opcode, eu_a, eu_b,
    output res_valid, res_data, res_tag, res_err, q_count
  );

  modport master (
    output in_valid, in_opcode, in_a, in_b, in_tag,
    output eu_busy, eu_done, eu_result, res_ready,
    input  in_ready, eu_start, eu_opcode, eu_a, eu_b,
    input  res_valid, res_data, res_tag, res_err, q_count
  );
endinterface

// File: rtl/eu_sync_fifo.sv
// eu_sync_fifo: small single-clock FIFO with occupancy count; push is ignored when full,
// pop is ignored when empty. Head is presented combinationally for same-cycle issue.
module eu_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage carries no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/eu_issue_queue.sv
// eu_issue_queue: buffers EU instructions, issues them one at a time via start/busy/done
// and returns tagged results in order. Optional macro: EU_ILLEGAL_OP_CHECK_EN.
module eu_issue_queue
  import eu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic             clk,
  input logic             rst,
  eu_issue_queue_if.slave bus
);
  localparam int ENTRY_W = 20 + TAG_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [ENTRY_W-1:0] head_entry;
  logic [TAG_W-1:0]   head_tag;
  logic [3:0]         head_op;
  logic [7:0]         head_a;
  logic [7:0]         head_b;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic               head_illegal;
  logic [CNT_W-1:0]   fifo_count;

  eu_state_e          state_reg;
  eu_state_e          state_next;
  logic               issue_pulse;
  logic               resp_valid;

  logic [3:0]         eu_opcode_reg;
  logic [7:0]         eu_a_reg;
  logic [7:0]         eu_b_reg;
  logic [TAG_W-1:0]   issued_tag_reg;
  logic [15:0]        res_data_reg;
  logic [TAG_W-1:0]   res_tag_reg;

  assign fifo_push = bus.in_valid && !fifo_full;
  assign {head_tag, head_op, head_a, head_b} = head_entry;

  eu_sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({bus.in_tag, bus.in_opcode, bus.in_a, bus.in_b}),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef EU_ILLEGAL_OP_CHECK_EN
  assign head_illegal = !fifo_empty && !is_legal_op(head_op);
`else
  assign head_illegal = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        // Illegal heads retire without touching the EU, so they need not wait for !busy.
        if (head_illegal)                     state_next = ST_RESP;
        else if (!fifo_empty && !bus.eu_busy) state_next = ST_ISSUE;
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (bus.eu_done)   state_next = ST_RESP;
      ST_RESP:  if (bus.res_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    issue_pulse = (state_reg == ST_ISSUE);
    resp_valid  = (state_reg == ST_RESP);
    fifo_pop    = (state_reg == ST_ISSUE) || ((state_reg == ST_IDLE) && head_illegal);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eu_opcode_reg  <= '0;
      eu_a_reg       <= '0;
      eu_b_reg       <= '0;
      issued_tag_reg <= '0;
      res_data_reg   <= '0;
      res_tag_reg    <= '0;
    end else begin
      if ((state_reg == ST_IDLE) && (state_next == ST_ISSUE)) begin
        eu_opcode_reg  <= head_op;
        eu_a_reg       <= head_a;
        eu_b_reg       <= head_b;
        issued_tag_reg <= head_tag;
      end
      if ((state_reg == ST_WAIT) && bus.eu_done) begin
        res_data_reg <= bus.eu_result;
        res_tag_reg  <= issued_tag_reg;
      end
`ifdef EU_ILLEGAL_OP_CHECK_EN
      if ((state_reg == ST_IDLE) && head_illegal) begin
        res_data_reg <= ILLEGAL_RESULT;
        res_tag_reg  <= head_tag;
      end
`endif
    end
  end

`ifdef EU_ILLEGAL_OP_CHECK_EN
  logic res_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      res_err_reg <= 1'b0;
    else if ((state_reg == ST_IDLE) && head_illegal) res_err_reg <= 1'b1;
    else if ((state_reg == ST_WAIT) && bus.eu_done)  res_err_reg <= 1'b0;
  end

  assign bus.res_err = res_err_reg;
`else
  assign bus.res_err = 1'b0;
`endif

  assign bus.in_ready  = !fifo_full;
  assign bus.q_count   = fifo_count;
  assign bus.eu_start  = issue_pulse;
  assign bus.eu_opcode = eu_opcode_reg;
  assign bus.eu_a      = eu_a_reg;
  assign bus.eu_b      = eu_b_reg;
  assign bus.res_valid = resp_valid;
  assign bus.res_data  = res_data_reg;
  assign bus.res_tag   = res_tag_reg;
endmodule

// File: tb/tb_eu_issue_queue.sv
// tb_eu_issue_queue: scoreboard bench for eu_issue_queue with a behavioural EU attached.
// Build with EU_ILLEGAL_OP_CHECK_EN defined to exercise the illegal-opcode path.
`timescale 1ns/1ps
module tb_eu_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eu_issue_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();
  eu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic             drv_valid     = 1'b0;
  logic [3:0]       drv_op        = 4'd0;
  logic [7:0]       drv_a         = 8'd0;
  logic [7:0]       drv_b         = 8'd0;
  logic [TAG_W-1:0] drv_tag       = '0;
  logic             drv_res_ready = 1'b0;
  logic             eu_busy_m     = 1'b0;
  logic             eu_done_m     = 1'b0;
  logic [15:0]      eu_result_m   = 16'd0;
  logic [15:0]      eu_pend       = 16'd0;
  int               eu_cnt        = 0;

  assign bus.in_valid  = drv_valid;
  assign bus.in_opcode = drv_op;
  assign bus.in_a      = drv_a;
  assign bus.in_b      = drv_b;
  assign bus.in_tag    = drv_tag;
  assign bus.res_ready = drv_res_ready;
  assign bus.eu_busy   = eu_busy_m;
  assign bus.eu_done   = eu_done_m;
  assign bus.eu_result = eu_result_m;

  typedef struct packed {logic [3:0] op; logic [7:0] a; logic [7:0] b;} iss_t;
  typedef struct packed {logic [15:0] data; logic [TAG_W-1:0] tag; logic err;} res_t;

  iss_t iss_q[$];
  res_t res_q[$];
  res_t res_log[$];
  iss_t mon_iss;
  res_t mon_exp;
  res_t mon_got;
  int   checks      = 0;
  int   errors      = 0;
  int   start_count = 0;
  int   res_count   = 0;
  bit   rand_on     = 1'b0;

  // Execution unit behaviour: results from plain arithmetic, MUL/DIV take several cycles.
  function automatic logic [15:0] eu_func(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    case (op)
      4'd0:    r = {8'd0, a} + {8'd0, b};
      4'd1:    r = {8'd0, a} - {8'd0, b};
      4'd2:    r = {8'd0, a & b};
      4'd3:    r = {8'd0, a | b};
      4'd4:    r = {8'd0, a ^ b};
      4'd5:    r = {8'd0, ~a};
      4'd8:    r = {8'd0, a} * {8'd0, b};
      4'd9:    r = (b == 8'd0) ? 16'hFFFF : {a % b, a / b};
      default: r = 16'd0;
    endcase
    return r;
  endfunction

  function automatic int eu_latency(input logic [3:0] op);
    if (op == 4'd8) return 4;
    if (op == 4'd9) return 6;
    return 1;
  endfunction

  function automatic bit model_legal(input logic [3:0] op);
    return (op <= 4'd5) || (op == 4'd8) || (op == 4'd9);
  endfunction

  // The EU ignores rst on purpose: a reset mid-operation leaves its done pulse stale.
  always @(posedge clk) begin
    eu_done_m   <= 1'b0;
    eu_result_m <= 16'($urandom);
    if (eu_cnt > 0) begin
      eu_cnt <= eu_cnt - 1;
      if (eu_cnt == 1) begin
        eu_done_m   <= 1'b1;
        eu_busy_m   <= 1'b0;
        eu_result_m <= eu_pend;
      end
    end else if (bus.eu_start) begin
      eu_cnt    <= eu_latency(bus.eu_opcode);
      eu_pend   <= eu_func(bus.eu_opcode, bus.eu_a, bus.eu_b);
      eu_busy_m <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_expect(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [TAG_W-1:0] tag);
    res_t r;
    bit   issued = 1'b1;
`ifdef EU_ILLEGAL_OP_CHECK_EN
    if (!model_legal(op)) issued = 1'b0;
`endif
    if (issued) begin
      iss_q.push_back({op, a, b});
      r.data = eu_func(op, a, b);
      r.err  = 1'b0;
    end else begin
      r.data = 16'hDEAD;
      r.err  = 1'b1;
    end
    r.tag = tag;
    res_q.push_back(r);
  endtask

  task automatic push_instr(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [TAG_W-1:0] tag);
    int k = 0;
    drv_valid = 1'b1; drv_op = op; drv_a = a; drv_b = b; drv_tag = tag;
    while (!bus.in_ready && k < 500) begin tick(); k++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout in_ready=0 required=1 @%0t", $time);
      drv_valid = 1'b0;
      return;
    end
    sb_expect(op, a, b, tag);
    tick();
    drv_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget, input string name);
    int k = 0;
    while (res_count < n && k < budget) begin tick(); k++; end
    check({name, "_results_arrived"}, 32'(res_count >= n), 32'd1);
  endtask

  task automatic check_reset_outputs(input string ctx);
    check({ctx, "_eu_start"},  32'(bus.eu_start),  32'd0);
    check({ctx, "_eu_opcode"}, 32'(bus.eu_opcode), 32'd0);
    check({ctx, "_eu_a"},      32'(bus.eu_a),      32'd0);
    check({ctx, "_eu_b"},      32'(bus.eu_b),      32'd0);
    check({ctx, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check({ctx, "_res_data"},  32'(bus.res_data),  32'd0);
    check({ctx, "_res_tag"},   32'(bus.res_tag),   32'd0);
    check({ctx, "_res_err"},   32'(bus.res_err),   32'd0);
    check({ctx, "_q_count"},   32'(bus.q_count),   32'd0);
    check({ctx, "_in_ready"},  32'(bus.in_ready),  32'd1);
  endtask

  // Monitor: every issue and every accepted result is popped against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.eu_start) begin
        start_count++;
        check("start_while_busy", 32'(bus.eu_busy), 32'd0);
        if (iss_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_issue opcode=0x%0h required=no_issue @%0t", bus.eu_opcode, $time);
        end else begin
          mon_iss = iss_q.pop_front();
          check("eu_opcode", 32'(bus.eu_opcode), 32'(mon_iss.op));
          check("eu_a",      32'(bus.eu_a),      32'(mon_iss.a));
          check("eu_b",      32'(bus.eu_b),      32'(mon_iss.b));
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        res_count++;
        mon_got.data = bus.res_data;
        mon_got.tag  = bus.res_tag;
        mon_got.err  = bus.res_err;
        res_log.push_back(mon_got);
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result data=0x%0h required=no_result @%0t", bus.res_data, $time);
        end else begin
          mon_exp = res_q.pop_front();
          check("res_data", 32'(bus.res_data), 32'(mon_exp.data));
          check("res_tag",  32'(bus.res_tag),  32'(mon_exp.tag));
          check("res_err",  32'(bus.res_err),  32'(mon_exp.err));
        end
        $display("result #%0d data=0x%04h tag=%0d err=%0d", res_count, bus.res_data, bus.res_tag, bus.res_err);
      end
    end
  end

  initial begin
    int base_s;
    int base_r;
    int k;
    bit bad;
    logic [15:0] exp_bad_data;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single ADD: start pulse two cycles after the push edge, result 15 tag 3
    drv_res_ready = 1'b1;
    base_s = start_count; base_r = res_count;
    drv_valid = 1'b1; drv_op = 4'd0; drv_a = 8'd10; drv_b = 8'd5; drv_tag = 4'd3;
    sb_expect(4'd0, 8'd10, 8'd5, 4'd3);
    tick();
    drv_valid = 1'b0;
    check("lat_q_count_c1", 32'(bus.q_count),  32'd1);
    check("lat_start_c1",   32'(bus.eu_start), 32'd0);
    tick();
    check("lat_start_c2",   32'(bus.eu_start), 32'd1);
    wait_results(base_r + 1, 50, "add");
    check("add_start_pulses", 32'(start_count - base_s), 32'd1);
    check("add_data", 32'(res_log[base_r].data), 32'd15);
    check("add_tag",  32'(res_log[base_r].tag),  32'd3);

    // Back-to-back MUL, DIV, SUB, XOR, then drain in order
    drv_res_ready = 1'b0;
    base_r = res_count;
    push_instr(4'd8, 8'd6,   8'd5,   4'd0);
    push_instr(4'd9, 8'd20,  8'd4,   4'd1);
    push_instr(4'd1, 8'd20,  8'd7,   4'd2);
    push_instr(4'd4, 8'hAA,  8'hCC,  4'd3);
    drv_res_ready = 1'b1;
    wait_results(base_r + 4, 200, "b2b");
    check("b2b_mul", 32'(res_log[base_r].data),     32'd30);
    check("b2b_div", 32'(res_log[base_r + 1].data), 32'd5);
    check("b2b_sub", 32'(res_log[base_r + 2].data), 32'd13);
    check("b2b_xor", 32'(res_log[base_r + 3].data), 32'h66);
    check("b2b_tag_order", 32'({res_log[base_r].tag, res_log[base_r + 1].tag, res_log[base_r + 2].tag, res_log[base_r + 3].tag}), 32'h0123);

    // Fill beyond DEPTH while the consumer stalls; result held stable in RESP
    drv_res_ready = 1'b0;
    base_r = res_count;
    push_instr(4'd0, 8'd1, 8'd1, 4'd4);
    k = 0;
    while (!bus.res_valid && k < 50) begin tick(); k++; end
    check("fill_first_valid", 32'(bus.res_valid), 32'd1);
    for (int i = 0; i < 4; i++) push_instr(4'(i + 2), 8'(i + 1), 8'hF0, 4'(5 + i));
    check("fill_q_count", 32'(bus.q_count),  32'd4);
    check("fill_in_ready", 32'(bus.in_ready), 32'd0);
    base_s = start_count;
    drv_valid = 1'b1; drv_op = 4'd3; drv_a = 8'h0F; drv_b = 8'hF0; drv_tag = 4'd9;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!bus.res_valid || bus.res_data !== 16'd2 || bus.res_tag !== 4'd4 || bus.in_ready || bus.eu_start) bad = 1'b1;
    end
    check("hold_stable", 32'(bad), 32'd0);
    check("hold_no_start", 32'(start_count - base_s), 32'd0);
    drv_res_ready = 1'b1;
    k = 0;
    while (!bus.eu_start && k < 20) begin tick(); k++; end
    check("fill_issue_seen", 32'(bus.eu_start), 32'd1);
    check("fill_issue_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("fill_reassert_in_ready", 32'(bus.in_ready), 32'd1);
    check("fill_reassert_q_count",  32'(bus.q_count),  32'd3);
    sb_expect(4'd3, 8'h0F, 8'hF0, 4'd9);
    tick();
    drv_valid = 1'b0;
    wait_results(base_r + 6, 300, "fill");

    // Reset while a MUL is in WAIT; its late done must not produce a result
    base_r = res_count;
    push_instr(4'd8, 8'd7, 8'd9, 4'd9);
    k = 0;
    while (!bus.eu_start && k < 20) begin tick(); k++; end
    check("rst_mul_issued", 32'(bus.eu_start), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("wait_rst");
    res_q.delete();
    iss_q.delete();
    tick();
    tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.res_valid || bus.q_count != 0) bad = 1'b1;
    end
    check("stale_done_ignored", 32'(bad), 32'd0);
    check("stale_no_result", 32'(res_count - base_r), 32'd0);

    // Opcode 0110 (tag 5) then OR AA|CC (tag 6)
    base_s = start_count; base_r = res_count;
    push_instr(4'd6, 8'd1, 8'd2, 4'd5);
    push_instr(4'd3, 8'hAA, 8'hCC, 4'd6);
    wait_results(base_r + 2, 100, "illegal");
`ifdef EU_ILLEGAL_OP_CHECK_EN
    exp_bad_data = 16'hDEAD;
    check("illegal_err", 32'(res_log[base_r].err), 32'd1);
    check("illegal_starts", 32'(start_count - base_s), 32'd1);
`else
    exp_bad_data = 16'h0000;
    check("illegal_err", 32'(res_log[base_r].err), 32'd0);
    check("illegal_starts", 32'(start_count - base_s), 32'd2);
`endif
    check("illegal_data", 32'(res_log[base_r].data), 32'(exp_bad_data));
    check("illegal_tag",  32'(res_log[base_r].tag),  32'd5);
    check("or_data", 32'(res_log[base_r + 1].data), 32'hEE);
    check("or_tag",  32'(res_log[base_r + 1].tag),  32'd6);
    check("or_err",  32'(res_log[base_r + 1].err),  32'd0);

    // Random traffic with a randomly stalling consumer
    base_r = res_count;
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          push_instr(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), TAG_W'($urandom));
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          tick();
          drv_res_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drv_res_ready = 1'b1;
    wait_results(base_r + 60, 3000, "random");
    repeat (3) tick();
    check("sb_results_drained", 32'(res_q.size()), 32'd0);
    check("sb_issues_drained",  32'(iss_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
